// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the data memory.
// The master side is the environment (requesters plus memory); the slave side is the arbiter.
interface data_mem_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_rvalid;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_lock;
    logic              p1_gnt;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_rvalid;

    logic              cpu_stall;

    logic [ADDR_W-1:0] mem_A;
    logic [DATA_W-1:0] mem_WD;
    logic              mem_WE;
    logic              mem_RE;
    logic [DATA_W-1:0] mem_RD;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
        output mem_RD,
        input  p0_gnt, p0_rdata, p0_rvalid,
        input  p1_gnt, p1_rdata, p1_rvalid,
        input  cpu_stall,
        input  mem_A, mem_WD, mem_WE, mem_RE
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
        input  mem_RD,
        output p0_gnt, p0_rdata, p0_rvalid,
        output p1_gnt, p1_rdata, p1_rvalid,
        output cpu_stall,
        output mem_A, mem_WD, mem_WE, mem_RE
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares the single-ported data memory between the CPU (port 0) and a loader/debug master (port 1).
// Round-robin on ties; port 1 may lock the memory for bursts bounded by MAX_BURST while port 0 waits.
module data_mem_arbiter #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_arbiter_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    logic              r_last_p1;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;
    logic              r_p0_rvalid;
    logic              r_p1_rvalid;

    logic              w_at_max;
    logic              w_override;
    logic              w_locked;
    logic              w_gnt0;
    logic              w_gnt1;

    // Grant decision; an exhausted burst yields exactly one slot to a waiting port 0
    always_comb begin
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        w_at_max   = (r_burst_cnt == CNT_W'(MAX_BURST));
        w_override = bus.p1_lock & w_at_max & bus.p0_req;
        w_locked   = bus.p1_lock & ~w_override;
        if (!rst) begin
            if (w_override) begin
                w_gnt0 = 1'b1;
            end else if (w_locked) begin
                w_gnt1 = bus.p1_req;
            end else if (bus.p0_req && bus.p1_req) begin
                w_gnt0 = r_last_p1;
                w_gnt1 = ~r_last_p1;
            end else begin
                w_gnt0 = bus.p0_req;
                w_gnt1 = bus.p1_req;
            end
        end
    end

    assign bus.p0_gnt    = w_gnt0;
    assign bus.p1_gnt    = w_gnt1;
    assign bus.cpu_stall = bus.p0_req & ~w_gnt0;

    assign bus.mem_A  = w_gnt1 ? bus.p1_addr  : bus.p0_addr;
    assign bus.mem_WD = w_gnt1 ? bus.p1_wdata : bus.p0_wdata;
    assign bus.mem_WE = (w_gnt0 & bus.p0_we) | (w_gnt1 & bus.p1_we);
    assign bus.mem_RE = (w_gnt0 & ~bus.p0_we) | (w_gnt1 & ~bus.p1_we);

    assign bus.p0_rdata  = r_p0_rdata;
    assign bus.p1_rdata  = r_p1_rdata;
    assign bus.p0_rvalid = r_p0_rvalid;
    assign bus.p1_rvalid = r_p1_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_p1   <= 1'b1;
            r_burst_cnt <= '0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
        end else begin
            if (w_gnt0) begin
                r_last_p1 <= 1'b0;
            end else if (w_gnt1) begin
                r_last_p1 <= 1'b1;
            end

            // Burst length only counts while the lock is asserted
            if (!bus.p1_lock || w_gnt0) begin
                r_burst_cnt <= '0;
            end else if (w_gnt1 && !w_at_max) begin
                r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end

            r_p0_rvalid <= w_gnt0 & ~bus.p0_we;
            r_p1_rvalid <= w_gnt1 & ~bus.p1_we;
            if (w_gnt0 && !bus.p0_we) begin
                r_p0_rdata <= bus.mem_RD;
            end
            if (w_gnt1 && !bus.p1_we) begin
                r_p1_rdata <= bus.mem_RD;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them and tracks the read-data pipeline.
module tb_data_mem_arbiter;
    typedef struct {
        logic        rst;
        logic        g0;
        logic        g1;
        logic        stall;
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [15:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] tb_mem [0:255];
    exp_t        exp_q [$];
    int          n_checks;
    int          n_errors;

    logic        pend0;
    logic        pend1;
    logic [15:0] hold0;
    logic [15:0] hold1;

    data_mem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    data_mem_arbiter #(.DATA_W(16), .ADDR_W(16), .MAX_BURST(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write at the clock edge
    assign bus.mem_RD = tb_mem[bus.mem_A[7:0]];
    always @(posedge clk) begin
        if (rst) begin
            tb_mem[4] <= 16'hBEEF;
        end else if (bus.mem_WE) begin
            tb_mem[bus.mem_A[7:0]] <= bus.mem_WD;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares the current cycle against the popped expectation
    initial begin
        pend0 = 1'b0;
        pend1 = 1'b0;
        hold0 = 16'h0000;
        hold1 = 16'h0000;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                chk("p0_rvalid", 16'(bus.p0_rvalid), 16'(pend0));
                chk("p1_rvalid", 16'(bus.p1_rvalid), 16'(pend1));
                chk("p0_rdata", bus.p0_rdata, hold0);
                chk("p1_rdata", bus.p1_rdata, hold1);
                e = exp_q.pop_front();
                chk("p0_gnt", 16'(bus.p0_gnt), 16'(e.g0));
                chk("p1_gnt", 16'(bus.p1_gnt), 16'(e.g1));
                chk("cpu_stall", 16'(bus.cpu_stall), 16'(e.stall));
                chk("mem_WE", 16'(bus.mem_WE), 16'(e.we));
                chk("mem_RE", 16'(bus.mem_RE), 16'(e.re));
                chk("mem_A", bus.mem_A, e.addr);
                pend0 = e.g0 & e.re;
                pend1 = e.g1 & e.re;
                if (e.rst) begin
                    hold0 = 16'h0000;
                    hold1 = 16'h0000;
                end else if (pend0) begin
                    hold0 = e.rdata;
                end else if (pend1) begin
                    hold1 = e.rdata;
                end
            end
        end
    end

    // One cycle of stimulus plus its expected response
    task automatic cyc(input logic r, input logic lk,
                       input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1,
                       input logic eg0, input logic eg1, input logic est, input logic ewe,
                       input logic ere, input logic [15:0] eaddr, input logic [15:0] erd);
        exp_t e;
        rst          = r;
        bus.p1_lock  = lk;
        bus.p0_req   = r0;
        bus.p0_we    = w0;
        bus.p0_addr  = a0;
        bus.p0_wdata = d0;
        bus.p1_req   = r1;
        bus.p1_we    = w1;
        bus.p1_addr  = a1;
        bus.p1_wdata = d1;
        e.rst   = r;
        e.g0    = eg0;
        e.g1    = eg1;
        e.stall = est;
        e.we    = ewe;
        e.re    = ere;
        e.addr  = eaddr;
        e.rdata = erd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        bus.p1_lock  = 1'b0;
        bus.p0_req   = 1'b0;
        bus.p0_we    = 1'b0;
        bus.p0_addr  = 16'h0000;
        bus.p0_wdata = 16'h0000;
        bus.p1_req   = 1'b0;
        bus.p1_we    = 1'b0;
        bus.p1_addr  = 16'h0000;
        bus.p1_wdata = 16'h0000;
        @(posedge clk);
        #1;

        // Reset: no grants; cpu_stall follows p0_req
        cyc(1,0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,0,16'h0000,16'h0000);
        cyc(1,0, 1,0,16'h0004,16'h0000, 0,0,16'h0000,16'h0000, 0,0,1,0,0,16'h0004,16'h0000);
        // Single port-0 read
        cyc(0,0, 1,0,16'h0004,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0,0,1,16'h0004,16'hBEEF);
        // Single port-1 write, leaves last_p1=1
        cyc(0,0, 0,0,16'h0000,16'h0000, 1,1,16'h0030,16'h5555, 0,1,0,1,0,16'h0030,16'h0000);
        // Ties: P0, P1, P0, P1
        for (int k = 0; k < 2; k++) begin
            cyc(0,0, 1,0,16'h0004,16'h0000, 1,0,16'h0030,16'h0000, 1,0,0,0,1,16'h0004,16'hBEEF);
            cyc(0,0, 1,0,16'h0004,16'h0000, 1,0,16'h0030,16'h0000, 0,1,1,0,1,16'h0030,16'h5555);
        end
        cyc(0,0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,0,16'h0000,16'h0000);

        // Locked burst: 8 port-1 writes, one port-0 slot, then port 1 resumes
        for (int i = 0; i < 8; i++)
            cyc(0,1, 1,0,16'h0004,16'h0000, 1,1,16'(16'h0010 + i),16'(16'hA000 + i),
                0,1,1,1,0,16'(16'h0010 + i),16'h0000);
        cyc(0,1, 1,0,16'h0004,16'h0000, 1,1,16'h0018,16'hA008, 1,0,0,0,1,16'h0004,16'hBEEF);
        for (int i = 8; i < 12; i++)
            cyc(0,1, 1,0,16'h0004,16'h0000, 1,1,16'(16'h0010 + i),16'(16'hA000 + i),
                0,1,1,1,0,16'(16'h0010 + i),16'h0000);
        // Locked, no port-1 request: port 0 stays blocked (burst count 4)
        cyc(0,1, 1,0,16'h0004,16'h0000, 0,0,16'h0000,16'h0000, 0,0,1,0,0,16'h0004,16'h0000);
        // Locked, nobody requests: idle
        cyc(0,1, 0,0,16'h0004,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,0,16'h0004,16'h0000);
        // Count was kept: only 4 more port-1 grants before port 0 gets its slot
        for (int i = 12; i < 16; i++)
            cyc(0,1, 1,0,16'h0004,16'h0000, 1,1,16'(16'h0010 + i),16'(16'hA000 + i),
                0,1,1,1,0,16'(16'h0010 + i),16'h0000);
        cyc(0,1, 1,0,16'h0004,16'h0000, 1,1,16'h0050,16'hDEAD, 1,0,0,0,1,16'h0004,16'hBEEF);
        cyc(0,1, 0,0,16'h0000,16'h0000, 1,1,16'h0050,16'hDEAD, 0,1,0,1,0,16'h0050,16'h0000);
        cyc(0,0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,0,16'h0000,16'h0000);

        // Burst count 3, then port 0 asks with no port-1 request: blocked
        for (int i = 0; i < 3; i++)
            cyc(0,1, 0,0,16'h0000,16'h0000, 1,1,16'(16'h0040 + i),16'(16'hC000 + i),
                0,1,0,1,0,16'(16'h0040 + i),16'h0000);
        for (int k = 0; k < 2; k++)
            cyc(0,1, 1,0,16'h0004,16'h0000, 0,0,16'h0000,16'h0000, 0,0,1,0,0,16'h0004,16'h0000);
        // Burst count 5, then reset with a pending port-1 read
        for (int i = 3; i < 5; i++)
            cyc(0,1, 0,0,16'h0000,16'h0000, 1,1,16'(16'h0040 + i),16'(16'hC000 + i),
                0,1,0,1,0,16'(16'h0040 + i),16'h0000);
        cyc(1,1, 0,0,16'h0000,16'h0000, 1,0,16'h0030,16'h0000, 0,0,0,0,0,16'h0000,16'h0000);
        // After reset the first tie goes to port 0
        cyc(0,0, 1,0,16'h0004,16'h0000, 1,0,16'h0030,16'h0000, 1,0,0,0,1,16'h0004,16'hBEEF);
        cyc(0,0, 0,0,16'h0000,16'h0000, 1,0,16'h0030,16'h0000, 0,1,0,0,1,16'h0030,16'h5555);

        // Write then read same address from the other port
        cyc(0,0, 1,1,16'h0020,16'h1234, 0,0,16'h0000,16'h0000, 1,0,0,1,0,16'h0020,16'h0000);
        cyc(0,0, 0,0,16'h0000,16'h0000, 1,0,16'h0020,16'h0000, 0,1,0,0,1,16'h0020,16'h1234);
        cyc(0,0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,0,16'h0000,16'h0000);
        cyc(0,0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,0,16'h0000,16'h0000);
        @(negedge clk);

        chk("exp_q_drained", 16'(exp_q.size()), 16'h0000);
        for (int i = 0; i < 16; i++)
            chk("mem_burst", tb_mem[8'(16 + i)], 16'(16'hA000 + i));
        for (int i = 0; i < 5; i++)
            chk("mem_lock3", tb_mem[8'(64 + i)], 16'(16'hC000 + i));
        chk("mem_0x50", tb_mem[8'h50], 16'hDEAD);
        chk("mem_0x30", tb_mem[8'h30], 16'h5555);
        chk("mem_0x20", tb_mem[8'h20], 16'h1234);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single-ported 16-bit data memory between the CPU datapath (port 0: ALU result as address, RD2 as write data, MemWrite/MemRead) and a loader/debug master (port 1). It performs at most one memory access per cycle. Port 0 and port 1 alternate round-robin, and port 1 may lock the memory for bounded bursts. The block also produces the CPU stall that freezes the program counter while port 0 is denied.

## Interface
- DATA_W, 16, data width
- ADDR_W, 16, address width
- MAX_BURST, 8, maximum consecutive locked port-1 grants while port 0 waits (>=1)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- p0_req / p1_req  in  1  access request, held with its signals stable until granted
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  ADDR_W  access address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p1_lock  in  1  port 1 requests exclusive ownership for consecutive accesses
- p0_gnt / p1_gnt  out  1  access performed this cycle (combinational)
- p0_rdata / p1_rdata  out  DATA_W  registered read data
- p0_rvalid / p1_rvalid  out  1  one-cycle pulse, rdata valid
- cpu_stall  out  1  p0_req & ~p0_gnt
- mem_A  out  ADDR_W  to memory A
- mem_WD  out  DATA_W  to memory WD
- mem_WE  out  1  to memory WE
- mem_RE  out  1  to memory RE
- mem_RD  in  DATA_W  combinational memory read data

## Operation
- Registered state:
  - last_p1: last granted port was port 1. Reset value 1, so port 0 wins the first tie.
  - burst_cnt: 0..MAX_BURST, width clog2(MAX_BURST+1).
  - p0_rdata, p1_rdata, p0_rvalid, p1_rvalid.
- Lock mode (locked = p1_lock & (burst_cnt < MAX_BURST | ~p0_req)):
  - If p1_req: grant port 1.
  - Otherwise: no grant. Port 0 stays blocked; the memory is reserved.
- Unlocked mode:
  - Single request: grant it.
  - Both request: grant port 0 if last_p1, else port 1.
  - Neither: idle.
- Exactly one or zero gnt high per cycle. Both high is illegal.
- Memory side:
  - mem_A and mem_WD are muxed from the granted port, or port 0 when idle.
  - mem_WE = gnt & we of the granted port.
  - mem_RE = gnt & ~we of the granted port.
  - All memory strobes are 0 when idle.
- burst_cnt:
  - Increments (saturating at MAX_BURST) on each port-1 grant while p1_lock=1.
  - Clears on a port-0 grant or when p1_lock=0.
- When burst_cnt==MAX_BURST and p0_req=1, lock is overridden for exactly one arbitration:
  - Port 0 is granted and burst_cnt clears.
  - The lock then resumes.
- last_p1 updates only on a grant.
- rst=1:
  - All gnt, mem_WE and mem_RE are forced to 0 combinationally.
  - State returns to reset values at the edge.
  - Reset mid-burst drops the lock. A pending port-1 read produces no rvalid.

## Timing
- Grant latency: 0 cycles.
  - gnt rises in the same cycle as req when the port wins; there is no pipeline.
- Write: memory updates at the rising edge that ends the grant cycle.
- Read:
  - mem_RD is sampled at the edge ending the grant cycle into rdata.
  - rvalid is high for exactly the following cycle.
  - rdata holds its value until the next read on that port.
- The requester may drop req, or present a new request, in the cycle after gnt. Back-to-back accesses run one per cycle.
- cpu_stall is combinational. The PC must hold whenever cpu_stall=1.
- Reset values of outputs:
  - gnt=0, rvalid=0, rdata=0.
  - mem_WE=0, mem_RE=0.
  - mem_A and mem_WD follow port 0 inputs.
  - cpu_stall = p0_req while rst=0. Gated to 0 while rst=1 is not done: cpu_stall = p0_req during reset.

## Test plan
- **Reset, then single port-0 read:** rst high for 2 cycles, then p0_req=1, p0_we=0, p0_addr=0x0004, with memory[4]=0xBEEF.
  - Required: p0_gnt=1 that cycle, mem_RE=1, p0_rvalid=1 next cycle, p0_rdata=0xBEEF.
- **Tie round-robin:** p0_req and p1_req held high for 4 cycles, no lock.
  - Required: grant order P0, P1, P0, P1.
  - Required: cpu_stall=1 in cycles 2 and 4 only.
- **Locked burst with MAX_BURST=8:** p1_lock=1, p1 writes 0x0010..0x001B, p0_req held high.
  - Required: p1 granted 8 consecutive cycles, then p0 granted 1 cycle, then p1 resumes.
  - Required: memory contents match the written data.
- **Lock with no p1_req and no p0_req:** idle, mem_WE=mem_RE=0, burst_cnt unchanged.
- **Lock with no p1_req, p0_req=1, burst_cnt=3:** p0 is not granted, cpu_stall=1.
- **Reset mid-burst:** p1 locked, burst_cnt=5, then rst for 1 cycle.
  - Required: burst_cnt=0 and last_p1=1 after reset.
  - Required: no rvalid.
  - Required: the next tie grants port 0.
- **Write-then-read same address:** p0 writes 0x1234 to 0x0020, then p1 reads 0x0020 the next cycle.
  - Required: p1_rvalid=1 with p1_rdata=0x1234.
